// File: rtl/tx_rs_ddr.sv
// Transmit reconciliation sublayer: 64-bit core words out as two 32-bit XGMII columns, low half first.
// Define TXRS_FAULT_EN to build the 802.3ae local/remote link-fault response state machine.
module tx_rs_ddr #(
  parameter int TP        = 1,
  parameter int FAULT_HYS = 128
) (
  input  logic        txclk_2x,
  input  logic        reset,
  input  logic        tx_phase,
  input  logic [63:0] txd64,
  input  logic [7:0]  txc8,
  input  logic        local_fault,
  input  logic        remote_fault,
  output logic [31:0] txd,
  output logic [3:0]  txc,
  output logic [1:0]  link_state
);
  localparam logic [31:0] IDLE_D = 32'h07070707;
  localparam logic [3:0]  IDLE_C = 4'hF;
  localparam logic [31:0] RF_D   = 32'h0200009C;
  localparam logic [3:0]  RF_C   = 4'h1;

  // TP only delayed register updates in older behavioural models; registers here update at the edge.
  if (TP < 0 || FAULT_HYS < 2 || FAULT_HYS > 255) begin : g_bad_params
  end

  logic        phase;
  logic [31:0] hold_d;
  logic [3:0]  hold_c;
  logic        send_rf;
  logic        send_idle;
  logic        resume;
  logic [31:0] col_d;
  logic [3:0]  col_c;

`ifdef TXRS_FAULT_EN
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_LOCAL = 2'd1, ST_REMOTE = 2'd2} link_t;

  localparam logic [7:0] CNT_LAST = 8'(FAULT_HYS - 1);

  link_t      state;
  link_t      state_next;
  logic [7:0] col_cnt;
  logic [7:0] cnt_next;

  always_ff @(posedge txclk_2x or posedge reset) begin
    if (reset) begin
      state   <= ST_OK;
      col_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      col_cnt <= cnt_next;
    end
  end

  // Local fault has priority everywhere; any fault restarts the fault-free column count.
  always_comb begin
    state_next = state;
    cnt_next   = col_cnt;
    case (state)
      ST_OK: begin
        cnt_next = 8'd0;
        if (local_fault)       state_next = ST_LOCAL;
        else if (remote_fault) state_next = ST_REMOTE;
      end
      ST_LOCAL: begin
        if (local_fault) begin
          cnt_next = 8'd0;
        end else if (remote_fault) begin
          state_next = ST_REMOTE;
          cnt_next   = 8'd0;
        end else if (col_cnt >= CNT_LAST) begin
          state_next = ST_OK;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = col_cnt + 8'd1;
        end
      end
      ST_REMOTE: begin
        if (local_fault) begin
          state_next = ST_LOCAL;
          cnt_next   = 8'd0;
        end else if (remote_fault) begin
          cnt_next = 8'd0;
        end else if (col_cnt >= CNT_LAST) begin
          state_next = ST_OK;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = col_cnt + 8'd1;
        end
      end
      default: begin
        state_next = ST_OK;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign send_rf    = (state_next == ST_LOCAL);
  assign send_idle  = (state_next == ST_REMOTE);
  assign resume     = (state != ST_OK) && (state_next == ST_OK);
  assign link_state = state;
`else
  logic unused_fault;

  assign unused_fault = &{1'b0, local_fault, remote_fault};
  assign send_rf      = 1'b0;
  assign send_idle    = 1'b0;
  assign resume       = 1'b0;
  assign link_state   = 2'd0;
`endif

  // A pending high half is dropped when leaving a fault, so data restarts on a word boundary.
  always_comb begin
    col_d = IDLE_D;
    col_c = IDLE_C;
    if (send_rf) begin
      col_d = RF_D;
      col_c = RF_C;
    end else if (!send_idle) begin
      if (tx_phase) begin
        col_d = txd64[31:0];
        col_c = txc8[3:0];
      end else if (phase && !resume) begin
        col_d = hold_d;
        col_c = hold_c;
      end
    end
  end

  always_ff @(posedge txclk_2x or posedge reset) begin
    if (reset) begin
      txd    <= IDLE_D;
      txc    <= IDLE_C;
      phase  <= 1'b0;
      hold_d <= 32'd0;
      hold_c <= 4'd0;
    end else begin
      txd   <= col_d;
      txc   <= col_c;
      phase <= tx_phase;
      if (tx_phase) begin
        hold_d <= txd64[63:32];
        hold_c <= txc8[7:4];
      end
    end
  end
endmodule

// File: tb/tb_tx_rs_ddr.sv
// Bench for tx_rs_ddr: column-queue reference model checked every cycle plus literal directed cases.
// Fault-response cases are compiled in when TXRS_FAULT_EN is defined, matching the DUT build.
module tb_tx_rs_ddr;
  localparam int HYS = 128;
  localparam logic [31:0] IDLE_D = 32'h07070707;
  localparam logic [31:0] RF_D   = 32'h0200009C;

  logic        txclk_2x = 1'b0;
  logic        reset;
  logic        tx_phase;
  logic [63:0] txd64;
  logic [7:0]  txc8;
  logic        local_fault;
  logic        remote_fault;
  logic [31:0] txd;
  logic [3:0]  txc;
  logic [1:0]  link_state;

  int tests = 0;
  int fails = 0;

  always #5 txclk_2x = ~txclk_2x;

  tx_rs_ddr #(.TP(1), .FAULT_HYS(HYS)) dut (
    .txclk_2x    (txclk_2x),
    .reset       (reset),
    .tx_phase    (tx_phase),
    .txd64       (txd64),
    .txc8        (txc8),
    .local_fault (local_fault),
    .remote_fault(remote_fault),
    .txd         (txd),
    .txc         (txc),
    .link_state  (link_state)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic apply_stimulus(input logic ph, input logic [63:0] d, input logic [7:0] c,
                                input logic lf, input logic rf);
    tx_phase     = ph;
    txd64        = d;
    txc8         = c;
    local_fault  = lf;
    remote_fault = rf;
    @(negedge txclk_2x);
  endtask

  // Reference model: mode 0 OK / 1 sending RF / 2 sending Idle, pending columns held in a queue.
  logic [31:0] exp_d;
  logic [3:0]  exp_c;
  logic [1:0]  exp_ls;
  logic [35:0] pend_q[$];
  logic [35:0] col;
  bit          have;
  int          mode = 0;
  int          prev_mode;
  longint      cyc = 0;
  longint      last_evt = 0;

  always @(posedge txclk_2x or posedge reset) begin
    if (reset) begin
      exp_d    = IDLE_D;
      exp_c    = 4'hF;
      exp_ls   = 2'd0;
      mode     = 0;
      cyc      = 0;
      last_evt = 0;
      pend_q.delete();
    end else begin
      cyc++;
      prev_mode = mode;
`ifdef TXRS_FAULT_EN
      if (local_fault || remote_fault) begin
        mode     = local_fault ? 1 : 2;
        last_evt = cyc;
      end else if (mode != 0 && (cyc - last_evt) >= HYS) begin
        mode = 0;
      end
`endif
      have = 0;
      col  = '0;
      if (pend_q.size() > 0) begin
        col  = pend_q.pop_front();
        have = 1;
      end
      if (tx_phase) begin
        pend_q.delete();
        col  = {txc8[3:0], txd64[31:0]};
        have = 1;
        pend_q.push_back({txc8[7:4], txd64[63:32]});
      end
      if (mode == 1) begin
        exp_d = RF_D;
        exp_c = 4'h1;
      end else if (mode == 2 || (prev_mode != 0 && !tx_phase) || !have) begin
        exp_d = IDLE_D;
        exp_c = 4'hF;
      end else begin
        exp_d = col[31:0];
        exp_c = col[35:32];
      end
      exp_ls = 2'(mode);
    end
  end

  always @(negedge txclk_2x) begin
    if (!reset) begin
      check_output("model_txd", txd, exp_d);
      check_output("model_txc", {28'd0, txc}, {28'd0, exp_c});
      check_output("model_link_state", {30'd0, link_state}, {30'd0, exp_ls});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rf_cnt;
    int stop_k;
    logic alt;
    reset        = 1'b1;
    tx_phase     = 1'b0;
    txd64        = 64'd0;
    txc8         = 8'd0;
    local_fault  = 1'b0;
    remote_fault = 1'b0;
    repeat (3) @(negedge txclk_2x);
    check_output("reset_txd", txd, IDLE_D);
    check_output("reset_txc", {28'd0, txc}, {28'd0, 4'hF});
    check_output("reset_link_state", {30'd0, link_state}, 32'd0);
    reset = 1'b0;
    @(negedge txclk_2x);

    $display("[TB] basic word split");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 64'h0706050403020100, 8'h00, 1'b0, 1'b0);
      check_output("t1_low_txd", txd, 32'h03020100);
      check_output("t1_low_txc", {28'd0, txc}, 32'd0);
      apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
      check_output("t1_high_txd", txd, 32'h07060504);
      check_output("t1_high_txc", {28'd0, txc}, 32'd0);
    end

    $display("[TB] frame start word");
    apply_stimulus(1'b1, 64'hD5555555555555FB, 8'h01, 1'b0, 1'b0);
    check_output("t2_low_txd", txd, 32'h555555FB);
    check_output("t2_low_txc", {28'd0, txc}, 32'd1);
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    check_output("t2_high_txd", txd, 32'hD5555555);
    check_output("t2_high_txc", {28'd0, txc}, 32'd0);
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    check_output("gap_idle_txd", txd, IDLE_D);

    $display("[TB] early re-sync");
    apply_stimulus(1'b1, 64'hAAAA0001AAAA0000, 8'h00, 1'b0, 1'b0);
    apply_stimulus(1'b1, 64'hBBBB0001BBBB0000, 8'h00, 1'b0, 1'b0);
    check_output("t5_second_low", txd, 32'hBBBB0000);
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    check_output("t5_second_high", txd, 32'hBBBB0001);
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);

`ifdef TXRS_FAULT_EN
    $display("[TB] local fault mid-frame");
    apply_stimulus(1'b1, 64'h0706050403020100, 8'h00, 1'b0, 1'b0);
    check_output("t3_low_before_fault", txd, 32'h03020100);
    apply_stimulus(1'b0, 64'h0706050403020100, 8'h00, 1'b1, 1'b0);
    check_output("t3_rf_txd", txd, RF_D);
    check_output("t3_rf_txc", {28'd0, txc}, 32'd1);
    check_output("t3_link_local", {30'd0, link_state}, 32'd1);
    rf_cnt = 1;
    stop_k = 0;
    for (int k = 1; k < 300; k++) begin
      apply_stimulus(1'(k % 2), 64'h0706050403020100, 8'h00, 1'b0, 1'b0);
      if (txd != RF_D) begin
        stop_k = k;
        break;
      end
      rf_cnt++;
    end
    check_output("t3_rf_column_count", 32'(rf_cnt), 32'd128);
    check_output("t3_resume_idle", txd, IDLE_D);
    check_output("t3_link_ok", {30'd0, link_state}, 32'd0);
    if (stop_k % 2 == 0) begin
      apply_stimulus(1'b1, 64'h0706050403020100, 8'h00, 1'b0, 1'b0);
      check_output("t3_data_resumes", txd, 32'h03020100);
    end
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);

    $display("[TB] repeated remote fault");
    for (int k = 0; k < 576; k++) begin
      apply_stimulus(1'(k % 2 == 0), {$urandom, $urandom}, 8'h00, 1'b0, 1'(k < 500 && k % 64 == 0));
      check_output("t4_idle_txd", txd, IDLE_D);
      check_output("t4_link_remote", {30'd0, link_state}, 32'd2);
    end
    apply_stimulus(1'b1, 64'h1122334455667788, 8'h00, 1'b1, 1'b0);
    check_output("t4_remote_to_local_txd", txd, RF_D);
    check_output("t4_remote_to_local_link", {30'd0, link_state}, 32'd1);
`else
    $display("[TB] fault inputs ignored");
    apply_stimulus(1'b1, 64'h0706050403020100, 8'h00, 1'b0, 1'b0);
    check_output("t3n_low", txd, 32'h03020100);
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    check_output("t3n_high_passes", txd, 32'h07060504);
    check_output("t3n_link_ok", {30'd0, link_state}, 32'd0);
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b1);
    check_output("t3n_idle_after", txd, IDLE_D);
`endif

    $display("[TB] reset mid-word");
    apply_stimulus(1'b1, 64'h0F0E0D0C0B0A0908, 8'h00, 1'b0, 1'b0);
    tx_phase    = 1'b0;
    local_fault = 1'b0;
    check_output("t6_before_reset", txd, 32'h0B0A0908);
    #2 reset = 1'b1;
    #1;
    check_output("t6_reset_txd", txd, IDLE_D);
    check_output("t6_reset_txc", {28'd0, txc}, {28'd0, 4'hF});
    check_output("t6_reset_link", {30'd0, link_state}, 32'd0);
    @(negedge txclk_2x);
    reset = 1'b0;
    @(negedge txclk_2x);

    $display("[TB] randomized traffic");
    alt = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      apply_stimulus(($urandom_range(0, 7) == 0) ? ~alt : alt, {$urandom, $urandom}, 8'($urandom),
                     1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 599) == 0));
      alt = ~alt;
    end
    apply_stimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
